load_scoreboard: RTL and testbench

LOAD_SCOREBOARD -- requirements
Module: load_scoreboard

---
 rtl/pipe_pkg.sv | 10 +
 rtl/ld_countdown.sv | 28 ++
 rtl/load_scoreboard.sv | 84 ++++++++
 tb/tb_load_scoreboard.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline constants for the load-use scoreboard.
// Register-file geometry, load latency and countdown width.
package pipe_pkg;
  localparam int NREG_DEF   = 8;
  localparam int RW_DEF     = $clog2(NREG_DEF);
  localparam int LD_LAT_DEF = 1;
  localparam int CNT_W_DEF  = 16;
  localparam int REG_ZERO   = 0;
  localparam int CD_W       = 3;
endpackage

// File: rtl/ld_countdown.sv
// Per-register load countdown.
// Reload wins; otherwise count down unless held.
module ld_countdown
  import pipe_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            hold,
  input  logic [CD_W-1:0] value,
  output logic            busy
);

  logic [CD_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= value;
    end else if (r_cnt != '0 && !hold) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign busy = (r_cnt != '0);

endmodule

// File: rtl/load_scoreboard.sv
// Load-use hazard scoreboard: stalls decode on RAW/WAW
// against in-flight loads, and counts stall cycles.
module load_scoreboard
  import pipe_pkg::*;
#(
  parameter int NREG   = NREG_DEF,
  parameter int RW     = $clog2(NREG),
  parameter int LD_LAT = LD_LAT_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [RW-1:0]    id_src1,
  input  logic [RW-1:0]    id_src2,
  input  logic             id_src1_used,
  input  logic             id_src2_used,
  input  logic [RW-1:0]    id_dst,
  input  logic             id_wr_en,
  input  logic             id_is_load,
  input  logic             id_flush,
  input  logic             mem_hold,
  input  logic             cnt_clr,
  output logic             stall,
  output logic [NREG-1:0]  pending,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [RW-1:0]   ZR  = RW'(REG_ZERO);
  localparam logic [CD_W-1:0] LAT = CD_W'(LD_LAT);

  logic [NREG-1:0] w_pend;
  logic            w_raw1;
  logic            w_raw2;
  logic            w_waw;
  logic            w_live;
  logic            w_issue;
  logic            w_set;
  logic [CNT_W-1:0] r_sc;

  assign w_pend[REG_ZERO] = 1'b0;

  genvar g;
  generate
    for (g = 1; g < NREG; g++) begin : g_cd
      ld_countdown u_cd (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_set && (id_dst == RW'(g))),
        .hold  (mem_hold),
        .value (LAT),
        .busy  (w_pend[g])
      );
    end
  endgenerate

  assign w_raw1 = id_src1_used && (id_src1 != ZR)
               && w_pend[id_src1];
  assign w_raw2 = id_src2_used && (id_src2 != ZR)
               && w_pend[id_src2];
  assign w_waw  = id_wr_en && (id_dst != ZR)
               && w_pend[id_dst];

  assign w_live  = id_valid && !id_flush;
  assign stall   = w_live && (w_raw1 || w_raw2 || w_waw);
  assign w_issue = w_live && !stall;
  // an issuing load can never target a busy register (waw stalls it)
  assign w_set   = w_issue && id_is_load && id_wr_en
                && (id_dst != ZR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sc <= '0;
    end else if (cnt_clr) begin
      r_sc <= '0;
    end else if (stall && r_sc != '1) begin
      r_sc <= r_sc + 1'b1;
    end
  end

  assign pending   = w_pend;
  assign stall_cnt = r_sc;

endmodule

// File: tb/tb_load_scoreboard.sv
// Scoreboard bench for load_scoreboard: driver pushes expected
// outputs from a reference model, monitor pops and compares.
module tb_load_scoreboard;
  localparam int NREG   = 8;
  localparam int RW     = 3;
  localparam int LD_LAT = 2;
  localparam int CNT_W  = 4;
  localparam int SMAX   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic id_valid, id_src1_used, id_src2_used;
  logic id_wr_en, id_is_load, id_flush, mem_hold, cnt_clr;
  logic [RW-1:0] id_src1, id_src2, id_dst;
  logic stall;
  logic [NREG-1:0] pending;
  logic [CNT_W-1:0] stall_cnt;

  always #5 clk = ~clk;

  load_scoreboard #(
    .NREG(NREG), .RW(RW), .LD_LAT(LD_LAT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid),
    .id_src1(id_src1), .id_src2(id_src2),
    .id_src1_used(id_src1_used), .id_src2_used(id_src2_used),
    .id_dst(id_dst), .id_wr_en(id_wr_en),
    .id_is_load(id_is_load), .id_flush(id_flush),
    .mem_hold(mem_hold), .cnt_clr(cnt_clr),
    .stall(stall), .pending(pending), .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic            stl;
    logic [NREG-1:0] pnd;
    logic [CNT_W-1:0] sc;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int tests = 0;
  int fails = 0;
  int rem[NREG];
  int scnt;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < NREG; r++) rem[r] = 0;
    scnt = 0;
  endtask

  task automatic step(
    input logic v, input logic [RW-1:0] s1, input logic u1,
    input logic [RW-1:0] s2, input logic u2,
    input logic [RW-1:0] d, input logic w, input logic ld,
    input logic fl, input logic h, input logic c);
    exp_t e;
    bit r1, r2, ww, st, iss;
    @(posedge clk); #1;
    id_valid = v; id_src1 = s1; id_src1_used = u1;
    id_src2 = s2; id_src2_used = u2; id_dst = d;
    id_wr_en = w; id_is_load = ld; id_flush = fl;
    mem_hold = h; cnt_clr = c;
    r1 = u1 && s1 != 0 && rem[s1] > 0;
    r2 = u2 && s2 != 0 && rem[s2] > 0;
    ww = w && d != 0 && rem[d] > 0;
    st = v && !fl && (r1 || r2 || ww);
    iss = v && !fl && !st;
    e.stl = st;
    for (int r = 0; r < NREG; r++) e.pnd[r] = rem[r] > 0;
    e.sc = CNT_W'(scnt);
    q.push_back(e);
    if (c) scnt = 0;
    else if (st && scnt < SMAX) scnt++;
    for (int r = 1; r < NREG; r++) begin
      if (iss && ld && w && d == RW'(r)) rem[r] = LD_LAT;
      else if (rem[r] > 0 && !h) rem[r]--;
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && q.size() > 0) begin
      m = q.pop_front();
      chk("stall", 32'(stall), 32'(m.stl));
      chk("pending", 32'(pending), 32'(m.pnd));
      chk("stall_cnt", 32'(stall_cnt), 32'(m.sc));
    end
  end

  initial begin
    rst_n = 1'b0;
    id_valid = 0; id_src1 = 0; id_src2 = 0;
    id_src1_used = 0; id_src2_used = 0; id_dst = 0;
    id_wr_en = 0; id_is_load = 0; id_flush = 0;
    mem_hold = 0; cnt_clr = 0;
    model_reset();
    #2;
    chk("rst_pending", 32'(pending), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_cnt", 32'(stall_cnt), 0);
    @(negedge clk); rst_n = 1'b1;

    // load r3 then dependent add held in decode
    step(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0);
    repeat (LD_LAT + 1) step(1, 3, 1, 0, 0, 6, 1, 0, 0, 0, 0);
    idle();
    // load r2 with a mem_hold bubble mid-countdown
    step(1, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0);
    step(1, 1, 1, 2, 1, 7, 1, 0, 0, 1, 0);
    step(1, 1, 1, 2, 1, 7, 1, 0, 0, 1, 0);
    repeat (LD_LAT + 1) step(1, 1, 1, 2, 1, 7, 1, 0, 0, 0, 0);
    idle();
    // waw: back-to-back loads writing r4
    step(1, 0, 0, 0, 0, 4, 1, 1, 0, 0, 0);
    repeat (LD_LAT + 1) step(1, 0, 0, 0, 0, 4, 1, 1, 0, 0, 0);
    repeat (LD_LAT) idle();
    // load to r0; unused source on pending reg; flush
    step(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    step(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0);
    step(1, 5, 0, 5, 0, 1, 1, 0, 0, 0, 0);
    step(1, 5, 1, 0, 0, 1, 1, 0, 1, 0, 0);
    step(1, 5, 1, 0, 0, 1, 1, 0, 0, 0, 1);
    repeat (LD_LAT) idle();

    // saturate the counter, then clear while stalling
    step(1, 0, 0, 0, 0, 6, 1, 1, 0, 0, 0);
    repeat (SMAX + 3) step(1, 6, 1, 0, 0, 1, 1, 0, 0, 1, 0);
    step(1, 6, 1, 0, 0, 1, 1, 0, 0, 1, 1);
    repeat (LD_LAT + 1) idle();

    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 9) < 8,
           RW'($urandom), $urandom_range(0, 9) < 7,
           RW'($urandom), $urandom_range(0, 9) < 7,
           RW'($urandom), $urandom_range(0, 9) < 7,
           $urandom_range(0, 9) < 4,
           $urandom_range(0, 9) < 1,
           $urandom_range(0, 9) < 2,
           $urandom_range(0, 29) < 1);
    end

    // asynchronous reset with r3 and r5 in flight
    step(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0);
    @(posedge clk); #1;
    id_valid = 0; mem_hold = 0; cnt_clr = 0;
    chk("pre_rst_pending", 32'(pending), 32'h28);
    rst_n = 1'b0;
    #1;
    chk("async_pending", 32'(pending), 0);
    chk("async_cnt", 32'(stall_cnt), 0);
    chk("async_stall", 32'(stall), 0);
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    step(1, 3, 1, 5, 1, 5, 1, 0, 0, 0, 0);
    idle();

    repeat (2) @(negedge clk);
    chk("queue_drain", 32'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
